// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory port arbiter: owner tags and the
// request payload carried through the grant mux.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  localparam int MAX_AW = 32;
  localparam int MAX_DW = 32;

  localparam logic [3:0] MEM_WE_READ = 4'b0000;

  // Sized for the widest supported bus; narrower instances zero-extend.
  typedef struct packed {
    logic [3:0]        we;
    logic [MAX_AW-1:0] addr;
    logic [MAX_DW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rsp_tag_pipe.sv
// Delay line carrying the owner of each read accept, so the returning
// memory data can be steered to the master that issued it.
module rsp_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic   CLK,
  input  logic   RST,
  input  owner_t tag_in,
  output owner_t tag_out
);

  owner_t stage_reg [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge CLK or posedge RST) begin
          if (RST) stage_reg[gi] <= OWN_NONE;
          else     stage_reg[gi] <= tag_in;
        end
      end else begin : g_body
        always_ff @(posedge CLK or posedge RST) begin
          if (RST) stage_reg[gi] <= OWN_NONE;
          else     stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign tag_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between the CPU and the debug master:
// combinational grant with starvation limit, read-response routing by tag.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          cpu_req,
  input  logic [3:0]    cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic [3:0]    dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  input  logic          dbg_lock,
  output logic          mem_cs,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output owner_t        owner
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
  owner_t        owner_reg, owner_next;
  owner_t        tag_in, tag_out;
  logic          hold_sat, cpu_acc, dbg_acc;
  mem_req_t      cpu_pkt, dbg_pkt, win_pkt;

  assign hold_sat = (hold_cnt_reg == HOLD_MAX);

  // Grants are forced low while reset is held so nothing reaches memory.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!RST) begin
      if (dbg_lock) begin
        dbg_gnt = dbg_req;
      end else if (cpu_req && dbg_req) begin
        cpu_gnt = hold_sat;
        dbg_gnt = !hold_sat;
      end else begin
        cpu_gnt = cpu_req;
        dbg_gnt = dbg_req;
      end
    end
  end

  assign cpu_acc = cpu_req && cpu_gnt;
  assign dbg_acc = dbg_req && dbg_gnt;

  assign cpu_pkt = '{we: cpu_we, addr: MAX_AW'(cpu_addr), wdata: MAX_DW'(cpu_wdata)};
  assign dbg_pkt = '{we: dbg_we, addr: MAX_AW'(dbg_addr), wdata: MAX_DW'(dbg_wdata)};

  always_comb begin
    win_pkt = '0;
    if (dbg_acc)      win_pkt = dbg_pkt;
    else if (cpu_acc) win_pkt = cpu_pkt;
  end

  assign mem_cs    = cpu_acc || dbg_acc;
  assign mem_we    = win_pkt.we;
  assign mem_addr  = win_pkt.addr[AW-1:0];
  assign mem_wdata = win_pkt.wdata[DW-1:0];

  // Counts debug wins over a waiting CPU; frozen while debug holds the lock.
  always_comb begin
    hold_cnt_next = hold_cnt_reg;
    if (!dbg_lock) begin
      if (cpu_gnt || !cpu_req)     hold_cnt_next = '0;
      else if (dbg_gnt && !hold_sat) hold_cnt_next = hold_cnt_reg + HW'(1);
    end
  end

  always_comb begin
    tag_in     = OWN_NONE;
    owner_next = owner_reg;
    if (dbg_acc) begin
      owner_next = OWN_DBG;
      if (dbg_we == MEM_WE_READ) tag_in = OWN_DBG;
    end else if (cpu_acc) begin
      owner_next = OWN_CPU;
      if (cpu_we == MEM_WE_READ) tag_in = OWN_CPU;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_cnt_reg <= '0;
      owner_reg    <= OWN_NONE;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
      owner_reg    <= owner_next;
    end
  end

  rsp_tag_pipe #(
    .DEPTH(MEM_LAT)
  ) u_tag_pipe (
    .CLK    (CLK),
    .RST    (RST),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  assign owner      = owner_reg;
  assign cpu_rvalid = (tag_out == OWN_CPU);
  assign dbg_rvalid = (tag_out == OWN_DBG);
  assign cpu_rdata  = mem_rdata;
  assign dbg_rdata  = mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master arbiter that shares a single synchronous memory port between the CPU data path and the UART debug controller, so the debugger can read and write data memory while the core runs. It sits between `risc_v`/`debug_controller` and the `Memory` instance. It owns the grant decision, starvation control, and routing of read data back to the requester that issued the read. The top level converts the memory's bidirectional bus to the split `mem_wdata`/`mem_rdata` ports used here.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width.
- `MEM_LAT`, 1, memory read latency in cycles (≥1).
- `MAX_HOLD`, 8, max consecutive debug grants while a CPU request waits.

Ports:
- `CLK`  in  1  single clock; all state on its rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `cpu_req`  in  1  CPU access request; must hold with its payload until granted.
- `cpu_we`  in  4  byte write enables; 0 means read.
- `cpu_addr`  in  AW  CPU address.
- `cpu_wdata`  in  DW  CPU write data.
- `cpu_gnt`  out  1  CPU request accepted this cycle.
- `cpu_rvalid`  out  1  CPU read data valid.
- `cpu_rdata`  out  DW  CPU read data.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: same as the CPU set, for the debug master.
- `dbg_lock`  in  1  debug owns the port exclusively while high (asserted during debug-held CPU reset).
- `mem_cs`  out  1  memory chip select.
- `mem_we`  out  4  memory byte enables.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data, valid `MEM_LAT` cycles after `mem_cs` with `mem_we==0`.
- `owner`  out  2  last granted master (`owner_t`); for LED debug tap.

## Operation
- An accept is a cycle with `x_req && x_gnt`. In that cycle `mem_cs=1` and `mem_we/addr/wdata` are driven from the winner; otherwise `mem_cs=0` and `mem_we=0`.
- Arbitration order:
  - `dbg_lock=1`: only debug can be granted; `cpu_gnt=0`.
  - Otherwise, if both request: debug wins, unless `hold_cnt==MAX_HOLD`, in which case the CPU wins.
  - A single requester always wins.
- `hold_cnt`, width `$clog2(MAX_HOLD+1)`:
  - Increments on a debug grant while `cpu_req=1` and `dbg_lock=0`.
  - Clears on any CPU grant, or in any cycle with `cpu_req=0`.
  - Saturates at `MAX_HOLD`.
  - Is frozen while `dbg_lock=1`.
- Each read accept pushes an owner tag into a `MEM_LAT`-deep pipe. Writes push `OWN_NONE`.
- At pipe output: if the tag is CPU, assert `cpu_rvalid` for 1 cycle with `cpu_rdata=mem_rdata`; if the tag is debug, do the same on the debug side. Otherwise both rvalid are 0.
- `x_rdata` is don't-care (drive `mem_rdata`) when `x_rvalid=0`.
- No write response; a write is complete at its accept edge.
- `owner` updates on every accept and holds otherwise. Reset value is `OWN_NONE`.
- Dropping `dbg_lock` mid-stream returns to normal priority next cycle. Reads already in flight still return to their issuer.

## Timing
- Grant is combinational from `req`, `dbg_lock` and registered `hold_cnt`, with zero-cycle latency. The `mem_*` outputs are combinational from the winner's payload.
- Read data returns exactly `MEM_LAT` cycles after the accept edge. Throughput is one accept per cycle, back-to-back, with mixed owners allowed.
- Reset (async assert, sync release): `hold_cnt=0`, tag pipe cleared to `OWN_NONE`, `owner=OWN_NONE`, all `rvalid=0`.
  - `gnt` and `mem_cs` are gated to 0 while `RST=1`.
  - Reads in flight at reset are dropped and never return.
- A simultaneous CPU request and saturated counter grants the CPU that cycle. The counter clears at that edge.

## Structure
- Package `mem_arb_pkg`:
  - `typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_t`.
  - `mem_req_t` struct holding `we`, `addr`, `wdata`.
  - `MEM_WE_READ = 4'b0000`.
- Sub-module `rsp_tag_pipe`: `MEM_LAT`-deep `owner_t` shift register with async reset to `OWN_NONE`.
- The arbiter core (counter, grant mux, response demux) stays in `mem_port_arbiter`.

## Test plan
- CPU-only read of `0x0000_0010` (memory holds `0xDEAD_BEEF`) → `cpu_gnt` same cycle; `cpu_rvalid=1`, `cpu_rdata=0xDEAD_BEEF` `MEM_LAT` cycles later; `dbg_rvalid` stays 0.
- Debug write `we=4'hF`, addr `0x20`, data `0x1234_5678`, then CPU read of `0x20` next cycle → memory written; CPU receives `0x1234_5678`; `owner` goes `OWN_DBG` then `OWN_CPU`.
- Both request continuously, `MAX_HOLD=8`, `dbg_lock=0` → grant pattern repeats 8 debug grants then 1 CPU grant.
- `dbg_lock=1` with `cpu_req` held for 20 cycles → `cpu_gnt=0` throughout, `hold_cnt` unchanged. On release, CPU is granted only when debug is idle or the counter is saturated.
- Interleaved reads every cycle D,C,D,C with `MEM_LAT=2` → each `rvalid` pulse lands at its issuer 2 cycles after its accept, with no swaps.
- Assert `RST` 1 cycle after a CPU read accept with `MEM_LAT=2` → no `cpu_rvalid` ever appears; all outputs 0 during reset; normal grants resume on the first cycle after release.
